// File: rtl/bmu_wb_queue_if.sv
// rtl/bmu_wb_queue_if.sv - issue credit and writeback handshake bundle for the BMU writeback queue
interface bmu_wb_queue_if #(
    parameter int TAG_W = 5
);
    logic             issue_valid;
    logic [TAG_W-1:0] issue_tag;
    logic             issue_ready;
    logic             wb_valid;
    logic             wb_ready;
    logic [31:0]      wb_data;
    logic [TAG_W-1:0] wb_tag;
    logic             wb_error;

    modport slave (
        input  issue_valid,
        input  issue_tag,
        input  wb_ready,
        output issue_ready,
        output wb_valid,
        output wb_data,
        output wb_tag,
        output wb_error
    );

    modport master (
        output issue_valid,
        output issue_tag,
        output wb_ready,
        input  issue_ready,
        input  wb_valid,
        input  wb_data,
        input  wb_tag,
        input  wb_error
    );
endinterface

// File: rtl/bmu_wb_queue.sv
// rtl/bmu_wb_queue.sv - credit-throttled in-order writeback queue capturing BMU results one cycle after issue
module bmu_wb_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    bmu_wb_queue_if.slave            bus,
    input  logic                     flush,
    input  logic [31:0]              bmu_result,
    input  logic                     bmu_error,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         err_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CQ_W  = PTR_W + 1;
    localparam logic [CQ_W-1:0] DEPTH_C = CQ_W'(DEPTH);

    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic             err_q  [DEPTH];
    logic             err_d  [DEPTH];
    logic [TAG_W-1:0] tag_q  [DEPTH];
    logic [TAG_W-1:0] tag_d  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CQ_W-1:0]  count_q, count_d;
    logic             inflight_vld_q, inflight_vld_d;
    logic [TAG_W-1:0] inflight_tag_q, inflight_tag_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic             issue_fire;
    logic             push;
    logic             pop;
    logic             head_vld;
    logic [CQ_W-1:0]  occupancy;

    // An in-flight op already owns a slot, so credit covers both queued and in-flight.
    assign occupancy       = count_q + CQ_W'(inflight_vld_q);
    assign bus.issue_ready = !rst && !flush && (occupancy < DEPTH_C);
    assign issue_fire      = bus.issue_valid && bus.issue_ready;

    assign head_vld = !rst && (count_q != '0);
    assign push     = inflight_vld_q && !flush;
    assign pop      = head_vld && bus.wb_ready && !flush;

    assign bus.wb_valid = head_vld;
    assign bus.wb_data  = head_vld ? data_q[rd_ptr_q] : '0;
    assign bus.wb_tag   = head_vld ? tag_q[rd_ptr_q]  : '0;
    assign bus.wb_error = head_vld ? err_q[rd_ptr_q]  : 1'b0;
    assign count        = rst ? '0 : count_q;
    assign err_count    = rst ? '0 : err_count_q;

    always_comb begin
        data_d         = data_q;
        err_d          = err_q;
        tag_d          = tag_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        err_count_d    = err_count_q;
        inflight_vld_d = issue_fire;
        inflight_tag_d = issue_fire ? bus.issue_tag : inflight_tag_q;

        if (push) begin
            data_d[wr_ptr_q] = bmu_result;
            err_d[wr_ptr_q]  = bmu_error;
            tag_d[wr_ptr_q]  = inflight_tag_q;
            wr_ptr_d         = wr_ptr_q + 1'b1;
            if (bmu_error && (err_count_q != '1)) begin
                err_count_d = err_count_q + 1'b1;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CQ_W'(push) - CQ_W'(pop);

        // Flush discards queued entries and the op whose result lands this cycle.
        if (flush) begin
            wr_ptr_d       = '0;
            rd_ptr_d       = '0;
            count_d        = '0;
            inflight_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            inflight_vld_q <= 1'b0;
            inflight_tag_q <= '0;
            err_count_q    <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            inflight_vld_q <= inflight_vld_d;
            inflight_tag_q <= inflight_tag_d;
            err_count_q    <= err_count_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
        err_q  <= err_d;
        tag_q  <= tag_d;
    end

    a_valid_in_is_fire: assert property (@(posedge clk) disable iff (rst)
        inflight_vld_q == $past(issue_fire));
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count_q >= DEPTH_C)));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && (count_q == '0)));
endmodule

// File: tb/tb_bmu_wb_queue.sv
// tb/tb_bmu_wb_queue.sv - scoreboard bench for bmu_wb_queue with a behavioural ADD-unit model
module tb_bmu_wb_queue;
    localparam int DEPTH = 4;
    localparam int TAG_W = 5;
    localparam int CNT_W = 8;
    localparam int ERR_MAX = (1 << CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   flush = 1'b0;
    logic [31:0]            bmu_result = '0;
    logic                   bmu_error = 1'b0;
    logic [$clog2(DEPTH):0] count;
    logic [CNT_W-1:0]       err_count;

    bmu_wb_queue_if #(.TAG_W(TAG_W)) bus ();

    bmu_wb_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .flush      (flush),
        .bmu_result (bmu_result),
        .bmu_error  (bmu_error),
        .count      (count),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      data;
        logic             err;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          exp_err = 0;
    logic [31:0] cur_a = '0;
    logic [31:0] cur_b = '0;
    bit          pend_vld = 1'b0;
    logic [31:0] pend_res = '0;
    bit          pend_err = 1'b0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic set_op(input bit v, input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
        bus.issue_valid = v;
        bus.issue_tag   = t;
        cur_a           = a;
        cur_b           = b;
    endtask

    // One clock: model bookkeeping at negedge, then present the BMU result after posedge.
    task automatic step();
        logic [31:0] s;
        bit          ovf;
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
            pend_vld = 1'b0;
            exp_err  = 0;
        end else begin
            chk(err_count == CNT_W'(exp_err), "err_count", 64'(err_count), 64'(exp_err));
            if (pend_vld && !flush && pend_err && exp_err < ERR_MAX) exp_err++;
            pend_vld = 1'b0;
            if (flush) begin
                exp_q.delete();
            end else if (bus.issue_valid && bus.issue_ready) begin
                s   = cur_a + cur_b;
                ovf = (cur_a[31] == cur_b[31]) && (s[31] != cur_a[31]);
                exp_q.push_back('{data: s, err: ovf, tag: bus.issue_tag});
                pend_vld = 1'b1;
                pend_res = s;
                pend_err = ovf;
            end
        end
        @(posedge clk);
        #1;
        bmu_result = pend_vld ? pend_res : $urandom();
        bmu_error  = pend_vld ? pend_err : 1'($urandom());
    endtask

    task automatic drain(input int max_cycles);
        set_op(1'b0, '0, '0, '0);
        bus.wb_ready = 1'b1;
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) step();
        step();
        #1;
        chk(exp_q.size() == 0, "drain_empty", 64'(exp_q.size()), 64'd0);
        chk(count == '0, "drain_count", 64'(count), 64'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.wb_valid) begin
                    if (bus.wb_ready && !flush) begin
                        if (exp_q.size() == 0) begin
                            chk(1'b0, "unexpected_pop", 64'(bus.wb_data), 64'd0);
                        end else begin
                            e = exp_q.pop_front();
                            chk(bus.wb_data == e.data, "wb_data", 64'(bus.wb_data), 64'(e.data));
                            chk(bus.wb_tag == e.tag, "wb_tag", 64'(bus.wb_tag), 64'(e.tag));
                            chk(bus.wb_error == e.err, "wb_error", 64'(bus.wb_error), 64'(e.err));
                        end
                    end
                end else begin
                    chk({bus.wb_data, bus.wb_tag, bus.wb_error} == '0, "idle_zero",
                        64'({bus.wb_data, bus.wb_tag, bus.wb_error}), 64'd0);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin : driver
        int acc;
        bit fl;
        set_op(1'b0, '0, '0, '0);
        bus.wb_ready = 1'b0;

        // power-on reset
        #1;
        chk(bus.issue_ready == 1'b0, "rst_issue_ready", 64'(bus.issue_ready), 64'd0);
        chk(bus.wb_valid == 1'b0, "rst_wb_valid", 64'(bus.wb_valid), 64'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk(bus.issue_ready == 1'b1, "post_rst_ready", 64'(bus.issue_ready), 64'd1);
        chk(count == '0, "post_rst_count", 64'(count), 64'd0);
        chk(err_count == '0, "post_rst_err", 64'(err_count), 64'd0);

        // reset mid-stream with three entries queued
        for (int i = 0; i < 3; i++) begin
            set_op(1'b1, 32'(i + 1), 32'd10, TAG_W'(i));
            step();
        end
        set_op(1'b0, '0, '0, '0);
        step();
        step();
        #1;
        chk(count == 3, "midrst_pre_count", 64'(count), 64'd3);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk(bus.issue_ready == 1'b0, "midrst_ready", 64'(bus.issue_ready), 64'd0);
            chk(bus.wb_valid == 1'b0, "midrst_wb_valid", 64'(bus.wb_valid), 64'd0);
            chk(count == '0, "midrst_count", 64'(count), 64'd0);
            chk(err_count == '0, "midrst_err", 64'(err_count), 64'd0);
            step();
        end
        rst = 1'b0;
        #1;
        chk(bus.issue_ready == 1'b1, "midrst_ready_back", 64'(bus.issue_ready), 64'd1);
        chk(count == '0, "midrst_count_after", 64'(count), 64'd0);

        // single ADD 5+7, two-cycle latency
        bus.wb_ready = 1'b1;
        set_op(1'b1, 32'd5, 32'd7, 5'd3);
        step();
        set_op(1'b0, '0, '0, '0);
        #1;
        chk(bus.wb_valid == 1'b0, "add_n1_valid", 64'(bus.wb_valid), 64'd0);
        step();
        #1;
        chk(bus.wb_valid == 1'b1, "add_n2_valid", 64'(bus.wb_valid), 64'd1);
        chk(bus.wb_data == 32'h0000000C, "add_n2_data", 64'(bus.wb_data), 64'hC);
        chk(bus.wb_tag == 5'd3, "add_n2_tag", 64'(bus.wb_tag), 64'd3);
        chk(bus.wb_error == 1'b0, "add_n2_err", 64'(bus.wb_error), 64'd0);
        drain(8);

        // backpressure: only DEPTH credits
        bus.wb_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            set_op(1'b1, 32'($urandom_range(0, 1000)), 32'($urandom_range(0, 1000)), TAG_W'(i + 8));
            #1;
            if (bus.issue_ready) acc++;
            step();
        end
        chk(acc == DEPTH, "bp_accepted", 64'(acc), 64'(DEPTH));
        #1;
        chk(bus.issue_ready == 1'b0, "bp_ready_low", 64'(bus.issue_ready), 64'd0);
        chk(count == DEPTH, "bp_count_full", 64'(count), 64'(DEPTH));
        drain(12);
        #1;
        chk(bus.issue_ready == 1'b1, "bp_ready_back", 64'(bus.issue_ready), 64'd1);

        // signed overflow flags error
        bus.wb_ready = 1'b1;
        set_op(1'b1, 32'h7FFFFFFF, 32'h00000001, 5'd9);
        step();
        set_op(1'b0, '0, '0, '0);
        step();
        #1;
        chk(bus.wb_data == 32'h80000000, "ovf_data", 64'(bus.wb_data), 64'h80000000);
        chk(bus.wb_error == 1'b1, "ovf_err", 64'(bus.wb_error), 64'd1);
        chk(err_count == 1, "ovf_err_count", 64'(err_count), 64'd1);
        drain(8);

        // flush with two queued and one error op in flight
        bus.wb_ready = 1'b0;
        set_op(1'b1, 32'd1, 32'd2, 5'd20);
        step();
        set_op(1'b1, 32'd3, 32'd4, 5'd21);
        step();
        set_op(1'b1, 32'h7FFFFFFF, 32'd1, 5'd22);
        step();
        set_op(1'b0, '0, '0, '0);
        flush = 1'b1;
        #1;
        chk(count == 2, "flush_pre_count", 64'(count), 64'd2);
        chk(bus.issue_ready == 1'b0, "flush_ready", 64'(bus.issue_ready), 64'd0);
        step();
        flush = 1'b0;
        #1;
        chk(bus.wb_valid == 1'b0, "flush_wb_valid", 64'(bus.wb_valid), 64'd0);
        chk(count == '0, "flush_count", 64'(count), 64'd0);
        chk(err_count == 1, "flush_err_kept", 64'(err_count), 64'd1);
        bus.wb_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            chk(bus.wb_valid == 1'b0, "flush_no_ghost", 64'(bus.wb_valid), 64'd0);
        end

        // error counter saturation
        for (int i = 0; i < 300; i++) begin
            set_op(1'b1, 32'h7FFFFFFF, 32'd1, TAG_W'(i));
            step();
        end
        drain(10);
        chk(err_count == 8'd255, "err_saturate", 64'(err_count), 64'd255);

        // back-to-back throughput and pointer wrap
        bus.wb_ready = 1'b1;
        for (int k = 0; k < 14; k++) begin
            if (k < 10) set_op(1'b1, 32'($urandom_range(0, 9999)), 32'($urandom_range(0, 9999)), TAG_W'(k));
            else set_op(1'b0, '0, '0, '0);
            #1;
            chk(bus.wb_valid == (k >= 2 && k < 12), "thru_valid", 64'(bus.wb_valid), 64'(k >= 2 && k < 12));
            chk(count <= 1, "thru_count", 64'(count), 64'd1);
            if (k < 10) chk(bus.issue_ready == 1'b1, "thru_ready", 64'(bus.issue_ready), 64'd1);
            step();
        end
        drain(8);

        // randomized traffic with occasional flushes
        for (int i = 0; i < 600; i++) begin
            fl = ($urandom_range(0, 31) == 0);
            set_op(($urandom_range(0, 9) < 7), $urandom(), $urandom(), TAG_W'($urandom()));
            flush = fl;
            bus.wb_ready = fl ? 1'b0 : ($urandom_range(0, 3) != 0);
            step();
        end
        flush = 1'b0;
        drain(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
